// File: rtl/i2s_transmitter.sv
// Philips I2S serialiser: divides clk down to BCLK, shifts 16-bit words out MSB first
// with a one-BCLK delay after each LRCLK edge, and pulses ready once per channel slot.
module i2s_transmitter #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] sample_in,
  output logic        ready,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata
);

  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [15:0] shift;
  logic [15:0] hold;

  logic        div_tc;
  logic        fall_evt;
  logic        rise_evt;
  logic        load_slot;
  logic        capture;
  logic [4:0]  bit_nxt;
  logic [15:0] shift_nxt;

  always_comb begin
    div_tc    = (div_cnt == 8'(CLK_DIV - 1));
    fall_evt  = div_tc && bclk;
    rise_evt  = div_tc && !bclk;
    bit_nxt   = bit_cnt + 5'd1;
    load_slot = (bit_nxt[3:0] == 4'd1);
    shift_nxt = load_slot ? hold : {shift[14:0], 1'b0};
    // bit_cnt only moves on falling events, so the first rising event that still
    // sees a load-slot count is the one following that slot's ready pulse.
    capture   = rise_evt && (bit_cnt[3:0] == 4'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= 8'd0;
      bit_cnt <= 5'd31;
      shift   <= 16'd0;
      hold    <= 16'd0;
      bclk    <= 1'b0;
      lrclk   <= 1'b0;
      sdata   <= 1'b0;
      ready   <= 1'b0;
    end else if (!enable) begin
      // Idle but keep hold, so re-enabling first replays the last captured sample.
      div_cnt <= 8'd0;
      bit_cnt <= 5'd31;
      shift   <= 16'd0;
      bclk    <= 1'b0;
      lrclk   <= 1'b0;
      sdata   <= 1'b0;
      ready   <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (div_tc) begin
        div_cnt <= 8'd0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
      if (fall_evt) begin
        bit_cnt <= bit_nxt;
        lrclk   <= bit_nxt[4];
        shift   <= shift_nxt;
        sdata   <= shift_nxt[15];
        ready   <= load_slot;
      end
      if (capture) begin
        hold <= sample_in;
      end
    end
  end

endmodule
